// File: rtl/instr_sequencer_if.sv
// Control bus between the instruction sequencer and its surroundings:
// instruction source inputs (i_*) and datapath control outputs (o_*).
interface instr_sequencer_if;
    logic [15:0] i_instr;
    logic        i_load;
    logic        i_s;

    logic        o_w;
    logic        o_illegal;
    logic [2:0]  o_readnum;
    logic [2:0]  o_writenum;
    logic        o_write;
    logic        o_loada;
    logic        o_loadb;
    logic        o_loadc;
    logic        o_loads;
    logic        o_vsel;
    logic        o_asel;
    logic        o_bsel;
    logic [1:0]  o_shift;
    logic [1:0]  o_alu_op;
    logic [15:0] o_datapath_in;

    // Sequencer side
    modport slave (
        input  i_instr, i_load, i_s,
        output o_w, o_illegal, o_readnum, o_writenum, o_write,
               o_loada, o_loadb, o_loadc, o_loads,
               o_vsel, o_asel, o_bsel, o_shift, o_alu_op, o_datapath_in
    );

    // Instruction source / observer side
    modport master (
        output i_instr, i_load, i_s,
        input  o_w, o_illegal, o_readnum, o_writenum, o_write,
               o_loada, o_loadb, o_loadc, o_loads,
               o_vsel, o_asel, o_bsel, o_shift, o_alu_op, o_datapath_in
    );
endinterface

// File: rtl/instr_sequencer.sv
// Multicycle controller for the 16-bit datapath. Holds one instruction in IR,
// decodes it, and steps the datapath control lines through a fixed sequence.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// WAIT        | idle/ready (w=1); load captures IR, s starts execution
// DECODE      | classify IR; illegal opcodes pulse illegal and return
// WRITE_IMM   | write sign-extended imm8 into Rn
// GET_A       | read Rn into A
// GET_B       | read Rm into B
// ALU         | shift B, run ALU; load C (or status Z for CMP)
// WRITE_REG   | write C into Rd
module instr_sequencer (
    input  logic                  clk,
    input  logic                  reset,
    instr_sequencer_if.slave      bus
);

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_WRITE_IMM = 3'd2,
        S_GET_A     = 3'd3,
        S_GET_B     = 3'd4,
        S_ALU       = 3'd5,
        S_WRITE_REG = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_ir;

    logic [2:0]  w_opcode;
    logic [1:0]  w_op;
    logic [2:0]  w_rn;
    logic [2:0]  w_rd;
    logic [1:0]  w_sh;
    logic [2:0]  w_rm;

    logic        w_is_movi;
    logic        w_is_movr;
    logic        w_is_add;
    logic        w_is_cmp;
    logic        w_is_and;
    logic        w_is_mvn;

    logic        w_idle;
    logic        w_illegal;
    logic [2:0]  w_readnum;
    logic [2:0]  w_writenum;
    logic        w_write;
    logic        w_loada;
    logic        w_loadb;
    logic        w_loadc;
    logic        w_loads;
    logic        w_vsel;
    logic        w_asel;
    logic        w_bsel;
    logic [1:0]  w_shift;
    logic [1:0]  w_alu_op;

    assign w_opcode = r_ir[15:13];
    assign w_op     = r_ir[12:11];
    assign w_rn     = r_ir[10:8];
    assign w_rd     = r_ir[7:5];
    assign w_sh     = r_ir[4:3];
    assign w_rm     = r_ir[2:0];

    assign w_is_movi = (w_opcode == 3'b110) && (w_op == 2'b10);
    assign w_is_movr = (w_opcode == 3'b110) && (w_op == 2'b00);
    assign w_is_add  = (w_opcode == 3'b101) && (w_op == 2'b00);
    assign w_is_cmp  = (w_opcode == 3'b101) && (w_op == 2'b01);
    assign w_is_and  = (w_opcode == 3'b101) && (w_op == 2'b10);
    assign w_is_mvn  = (w_opcode == 3'b101) && (w_op == 2'b11);

    // IR only loads while idle so the word stays stable for a whole instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ir <= 16'h0000;
        end else if ((r_state == S_WAIT) && bus.i_load) begin
            r_ir <= bus.i_instr;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_WAIT;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and Moore control outputs from state plus IR fields
    always_comb begin
        w_next     = r_state;
        w_idle     = 1'b0;
        w_illegal  = 1'b0;
        w_readnum  = 3'd0;
        w_writenum = 3'd0;
        w_write    = 1'b0;
        w_loada    = 1'b0;
        w_loadb    = 1'b0;
        w_loadc    = 1'b0;
        w_loads    = 1'b0;
        w_vsel     = 1'b0;
        w_asel     = 1'b0;
        w_bsel     = 1'b0;
        w_shift    = 2'b00;
        w_alu_op   = 2'b00;

        case (r_state)
            S_WAIT: begin
                w_idle = 1'b1;
                if (bus.i_s) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_is_movi) begin
                    w_next = S_WRITE_IMM;
                end else if (w_is_movr || w_is_mvn) begin
                    w_next = S_GET_B;
                end else if (w_is_add || w_is_cmp || w_is_and) begin
                    w_next = S_GET_A;
                end else begin
                    w_illegal = 1'b1;
                    w_next    = S_WAIT;
                end
            end
            S_WRITE_IMM: begin
                w_vsel     = 1'b1;
                w_writenum = w_rn;
                w_write    = 1'b1;
                w_next     = S_WAIT;
            end
            S_GET_A: begin
                w_readnum = w_rn;
                w_loada   = 1'b1;
                w_next    = S_GET_B;
            end
            S_GET_B: begin
                w_readnum = w_rm;
                w_loadb   = 1'b1;
                w_next    = S_ALU;
            end
            S_ALU: begin
                w_shift = w_sh;
                // MOV reg passes shifted B through an add with A forced to zero
                w_asel   = w_is_movr;
                w_alu_op = w_is_movr ? 2'b00 : w_op;
                if (w_is_cmp) begin
                    w_loads = 1'b1;
                    w_next  = S_WAIT;
                end else begin
                    w_loadc = 1'b1;
                    w_next  = S_WRITE_REG;
                end
            end
            S_WRITE_REG: begin
                w_writenum = w_rd;
                w_write    = 1'b1;
                w_next     = S_WAIT;
            end
            default: begin
                w_next = S_WAIT;
            end
        endcase
    end

    assign bus.o_w           = w_idle;
    assign bus.o_illegal     = w_illegal;
    assign bus.o_readnum     = w_readnum;
    assign bus.o_writenum    = w_writenum;
    assign bus.o_write       = w_write;
    assign bus.o_loada       = w_loada;
    assign bus.o_loadb       = w_loadb;
    assign bus.o_loadc       = w_loadc;
    assign bus.o_loads       = w_loads;
    assign bus.o_vsel        = w_vsel;
    assign bus.o_asel        = w_asel;
    assign bus.o_bsel        = w_bsel;
    assign bus.o_shift       = w_shift;
    assign bus.o_alu_op      = w_alu_op;
    assign bus.o_datapath_in = {{8{r_ir[7]}}, r_ir[7:0]};

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: per-cycle expected control words are queued when
// an instruction is launched and popped each busy cycle; a small behavioural
// datapath checks the architectural results.
module tb_instr_sequencer;

    logic clk = 1'b0;
    logic reset;

    instr_sequencer_if bus();

    instr_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Control word: readnum, writenum, write, loada, loadb, loadc, loads,
    // vsel, asel, bsel, shift, aluop, illegal
    function automatic logic [18:0] mk(input logic [2:0] rdn, input logic [2:0] wrn,
                                       input logic wr, input logic la, input logic lb,
                                       input logic lc, input logic ls, input logic vs,
                                       input logic as, input logic bs,
                                       input logic [1:0] sh, input logic [1:0] alu,
                                       input logic ill);
        return {rdn, wrn, wr, la, lb, lc, ls, vs, as, bs, sh, alu, ill};
    endfunction

    function automatic logic [18:0] ctrl_now();
        return {bus.o_readnum, bus.o_writenum, bus.o_write, bus.o_loada, bus.o_loadb,
                bus.o_loadc, bus.o_loads, bus.o_vsel, bus.o_asel, bus.o_bsel,
                bus.o_shift, bus.o_alu_op, bus.o_illegal};
    endfunction

    logic [18:0] exp_q[$];

    task automatic push_expected(input logic [15:0] ins);
        logic [2:0] opc;
        logic [1:0] op;
        logic [2:0] rn;
        logic [2:0] rd;
        logic [1:0] sh;
        logic [2:0] rm;
        opc = ins[15:13]; op = ins[12:11]; rn = ins[10:8];
        rd = ins[7:5]; sh = ins[4:3]; rm = ins[2:0];
        if (opc == 3'b110 && op == 2'b10) begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
            exp_q.push_back(mk(0, rn, 1, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0));
        end else if (opc == 3'b110 && op == 2'b00) begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
            exp_q.push_back(mk(rm, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
            exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, sh, 2'b00, 0));
            exp_q.push_back(mk(0, rd, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        end else if (opc == 3'b101 && op == 2'b11) begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
            exp_q.push_back(mk(rm, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
            exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, sh, 2'b11, 0));
            exp_q.push_back(mk(0, rd, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        end else if (opc == 3'b101) begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
            exp_q.push_back(mk(rn, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
            exp_q.push_back(mk(rm, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
            if (op == 2'b01) begin
                exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, sh, 2'b01, 0));
            end else begin
                exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, sh, op, 0));
                exp_q.push_back(mk(0, rd, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
            end
        end else begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1));
        end
    endtask

    // Behavioural datapath driven by the sequencer's control lines
    logic [15:0] rf [8];
    logic [15:0] ra, rb, rc;
    logic        rz;
    logic [15:0] b_sh, a_in, b_in, alu_out;
    int          n_write_pulses = 0;

    initial begin
        for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
        ra = 16'h0; rb = 16'h0; rc = 16'h0; rz = 1'b0;
    end

    always_comb begin
        b_sh = rb;
        case (bus.o_shift)
            2'b01: b_sh = {rb[14:0], 1'b0};
            2'b10: b_sh = {1'b0, rb[15:1]};
            2'b11: b_sh = {rb[15], rb[15:1]};
            default: b_sh = rb;
        endcase
        a_in = bus.o_asel ? 16'h0000 : ra;
        b_in = bus.o_bsel ? {{11{bus.o_datapath_in[4]}}, bus.o_datapath_in[4:0]} : b_sh;
        alu_out = a_in + b_in;
        case (bus.o_alu_op)
            2'b01: alu_out = a_in - b_in;
            2'b10: alu_out = a_in & b_in;
            2'b11: alu_out = ~b_in;
            default: alu_out = a_in + b_in;
        endcase
    end

    always @(posedge clk) begin
        if (bus.o_write) begin
            rf[bus.o_writenum] <= bus.o_vsel ? bus.o_datapath_in : rc;
            n_write_pulses <= n_write_pulses + 1;
        end
        if (bus.o_loada) ra <= rf[bus.o_readnum];
        if (bus.o_loadb) rb <= rf[bus.o_readnum];
        if (bus.o_loadc) rc <= alu_out;
        if (bus.o_loads) rz <= (alu_out == 16'h0000);
    end

    // Called at a negedge with the DUT idle; returns at the negedge where w
    // is back to 1, so consecutive calls exercise back-to-back starts.
    task automatic run_instr(input logic [15:0] ins, input bit together, input bit junk_load);
        int cycles;
        int exp_len;
        logic [15:0] sx;
        sx = {{8{ins[7]}}, ins[7:0]};
        check_val("w_before_start", bus.o_w, 1);
        if (!together) begin
            bus.i_load = 1'b1; bus.i_instr = ins; bus.i_s = 1'b0;
            @(negedge clk);
        end
        bus.i_load = together; bus.i_instr = ins; bus.i_s = 1'b1;
        push_expected(ins);
        exp_len = exp_q.size();
        @(negedge clk);
        bus.i_load = 1'b0; bus.i_s = 1'b0;
        cycles = 0;
        while (bus.o_w == 1'b0 && cycles < 20) begin
            if (exp_q.size() != 0) begin
                check_val($sformatf("ctrl_%04h_c%0d", ins, cycles), ctrl_now(), exp_q.pop_front());
            end
            check_val("dp_in_busy", bus.o_datapath_in, sx);
            if (junk_load) begin
                bus.i_load = 1'b1; bus.i_instr = ~ins;
            end
            @(negedge clk);
            cycles++;
        end
        bus.i_load = 1'b0;
        check_val($sformatf("busy_cycles_%04h", ins), cycles, exp_len);
        check_val("wait_ctrl", ctrl_now(), 0);
        check_val("dp_in_wait", bus.o_datapath_in, sx);
        exp_q.delete();
    endtask

    int pulses_before;

    initial begin
        reset = 1'b1;
        bus.i_instr = 16'h0; bus.i_load = 1'b0; bus.i_s = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_w", bus.o_w, 1);
        check_val("rst_ctrl", ctrl_now(), 0);
        check_val("rst_dp_in", bus.o_datapath_in, 0);
        reset = 1'b0;
        @(negedge clk);

        // Abort an ADD in GET_B with an asynchronous reset
        bus.i_instr = 16'hA148; bus.i_load = 1'b1; bus.i_s = 1'b1;
        @(negedge clk);
        bus.i_load = 1'b0; bus.i_s = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("abort_in_getb", {bus.o_loadb, bus.o_readnum}, {1'b1, 3'd0});
        pulses_before = n_write_pulses;
        #1 reset = 1'b1;
        #1;
        check_val("abort_w", bus.o_w, 1);
        check_val("abort_write", bus.o_write, 0);
        check_val("abort_ir_clear", bus.o_datapath_in, 0);
        repeat (3) @(negedge clk);
        check_val("abort_no_write", n_write_pulses, pulses_before);
        reset = 1'b0;
        @(negedge clk);

        run_instr(16'hD007, 1'b1, 1'b0);
        run_instr(16'hD1FE, 1'b0, 1'b1);
        run_instr(16'hA148, 1'b1, 1'b1);
        check_val("R0", rf[0], 16'h0007);
        check_val("R1", rf[1], 16'hFFFE);
        check_val("R2", rf[2], 16'h000C);
        run_instr(16'hA800, 1'b1, 1'b0);
        check_val("Z_cmp", rz, 1);
        run_instr(16'hB860, 1'b0, 1'b0);
        check_val("R3", rf[3], 16'hFFF8);
        run_instr(16'hC099, 1'b1, 1'b0);
        check_val("R4", rf[4], 16'hFFFF);
        run_instr(16'hB2A1, 1'b1, 1'b1);
        check_val("R5", rf[5], 16'h000C);
        run_instr(16'hE000, 1'b1, 1'b0);
        run_instr(16'hD800, 1'b0, 1'b0);
        check_val("R5_kept", rf[5], 16'h000C);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multicycle controller that sequences the 16-bit datapath (register file, A/B/C registers, shifter, ALU, status flag) through one instruction at a time. It holds the instruction in an internal instruction register (IR) and decodes it. On a start request it steps the datapath control lines through a fixed state sequence, then returns to idle. It sits between the instruction source (switches or fetch logic) and the datapath, and also drives the datapath's `datapath_in` with the sign-extended immediate.

## Interface
- No parameters; all widths fixed at 16-bit data, 3-bit register numbers.
- `clk`  in  1  rising-edge clock shared with the datapath.
- `reset`  in  1  asynchronous, active-high; forces idle state and clears IR.
- `in`  in  16  instruction word.
- `load`  in  1  capture `in` into IR at the clock edge (honoured only while idle).
- `s`  in  1  start: begin executing IR (sampled only while idle).
- `w`  out  1  idle/ready; 1 only in WAIT.
- `illegal`  out  1  one-cycle pulse when IR decodes to an unsupported opcode.
- `readnum`, `writenum`  out  3  register file read/write selects.
- `write`, `loada`, `loadb`, `loadc`, `loads`  out  1  register enables.
- `vsel`, `asel`, `bsel`  out  1  datapath mux selects.
- `shift`, `ALUop`  out  2  shifter op, ALU op.
- `datapath_in`  out  16  sign-extended IR[7:0].

## Operation
- Fields: opcode IR[15:13], op IR[12:11], Rn IR[10:8], Rd IR[7:5], sh IR[4:3], Rm IR[2:0].
- Supported instructions:
  - MOV Rn,#imm8 (110/10)
  - MOV Rd,Rm{,sh} (110/00)
  - ADD (101/00)
  - CMP (101/01)
  - AND (101/10)
  - MVN (101/11)
- Any other opcode/op is illegal.
- States: WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, WRITE_REG.
- Outputs are a Moore function of state plus IR fields. Every control not listed for a state is 0.
  - WAIT: `w`=1. On `s`=1, go to DECODE.
  - DECODE: no controls asserted.
    - MOV imm goes to WRITE_IMM.
    - MOV reg and MVN go to GET_B.
    - ADD, CMP and AND go to GET_A.
    - Illegal: `illegal`=1, go to WAIT.
  - WRITE_IMM: `vsel`=1, `writenum`=Rn, `write`=1. Go to WAIT.
  - GET_A: `readnum`=Rn, `loada`=1. Go to GET_B.
  - GET_B: `readnum`=Rm, `loadb`=1. Go to ALU.
  - ALU: `shift`=sh, `bsel`=0, `ALUop`=op.
    - MOV reg: `asel`=1, `ALUop`=00.
    - CMP: `loads`=1, `loadc`=0, then go to WAIT.
    - ADD, AND, MVN, MOV reg: `loadc`=1, `loads`=0, then go to WRITE_REG.
  - WRITE_REG: `vsel`=0, `writenum`=Rd, `write`=1. Go to WAIT.
- `datapath_in` = {{8{IR[7]}}, IR[7:0]} in every state.
- `load` outside WAIT is ignored, so IR is stable for the whole instruction. `s` outside WAIT is ignored.
- `load` and `s` asserted in the same WAIT cycle:
  - IR captures the new word.
  - DECODE then uses that new word.

## Timing
- Reset (asynchronous, effective immediately):
  - state=WAIT, IR=0, `w`=1, `illegal`=0.
  - All enables are 0 and `datapath_in`=0.
  - Assertion mid-instruction aborts it with no further writes.
- Cycles from the `s`-sampling edge until `w` returns to 1:
  - MOV imm: 2.
  - Illegal: 1.
  - CMP: 4.
  - MOV reg and MVN: 4.
  - ADD and AND: 5.
- Datapath state updates:
  - Register file write occurs at the edge leaving WRITE_IMM or WRITE_REG.
  - C register loads at the edge leaving ALU.
  - Z loads at the edge leaving ALU (CMP only).
- `w`=1 in the same cycle the final write has just committed, so a back-to-back `s` is accepted on the next edge.

## Test plan
- Reset mid-ADD (assert in GET_B) -> `w`=1 immediately, `write` never pulses, IR=0x0000.
- load 0xD007, s -> WRITE_IMM with `writenum`=0, `vsel`=1, `datapath_in`=0x0007; `w` back after 2 cycles.
- load 0xD1FE (MOV R1,#-2), s -> `datapath_in`=0xFFFE, `writenum`=1.
- load 0xA148 (ADD R2,R1,R0,LSL#1), s:
  - State sequence: GET_A(`readnum`=1) -> GET_B(`readnum`=0) -> ALU(`shift`=01, `ALUop`=00) -> WRITE_REG(`writenum`=2).
  - With the datapath attached, R2=0x000C after R0=7 and R1=-2.
  - 5 busy cycles.
- load 0xA800 (CMP R0,R0) -> `loads`=1 in ALU, no `write` and no `loadc` pulse, Z_out=1 with the datapath attached.
- load 0xB860 (MVN R3,R0) -> GET_B, ALU(`ALUop`=11), WRITE_REG(`writenum`=3), R3=0xFFF8.
- load 0xE000, then s -> `illegal` pulses for 1 cycle, no enables asserted.
- `load` asserted while busy is ignored.
